// File: rtl/reg_file_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_pkg
//   Shared constants, types and helpers for the parametrised register file.
//   - DEF_WIDTH / DEF_NREG : default data width and register count
//   - calc_aw()            : address width for a given register count
//   - addr_ok()            : true when an address names a real register
//   - src_sel_e            : read-port bypass source select
// ---------------------------------------------------------------------------
package reg_file_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_NREG  = 4;

   // Read operand source: stored value, same-cycle writeback, same-cycle load.
   typedef enum logic [1:0] {
      SRC_REG  = 2'd0,
      SRC_WB   = 2'd1,
      SRC_LOAD = 2'd2
   } src_sel_e;

   // A single register still needs one address bit.
   function automatic int calc_aw(input int nreg);
      return (nreg < 2) ? 1 : $clog2(nreg);
   endfunction

   // NREG need not be a power of two, so some encodable addresses are holes.
   function automatic logic addr_ok(input int unsigned addr, input int unsigned nreg);
      return addr < nreg;
   endfunction

endpackage

// File: rtl/reg_file_param_if.sv
// ---------------------------------------------------------------------------
// reg_file_param_if
//   Bundle of all register-file traffic between command decoder / ALU and the
//   register file.
//   master : drives load, writeback, issue and read addresses; observes results
//   slave  : the register file itself
//   Signals:
//     load_en/load_addr/load_data     host load request
//     wb_en/wb_addr/wb_data           ALU writeback
//     issue_en/issue_dest             issued instruction destination
//     rd_addr_a/rd_addr_b             read port addresses
//     rd_data_a/rd_data_b             registered operands
//     hazard_a/hazard_b               operand captured from a pending register
//     pending                         scoreboard, one bit per register
//     load_err                        one-cycle pulse for a rejected load
//     dbg_regs                        flat view, register i at [i*WIDTH +: WIDTH]
// ---------------------------------------------------------------------------
interface reg_file_param_if
   import reg_file_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NREG  = DEF_NREG
);
   localparam int AW = calc_aw(NREG);

   logic                  load_en;
   logic [AW-1:0]         load_addr;
   logic [WIDTH-1:0]      load_data;
   logic                  wb_en;
   logic [AW-1:0]         wb_addr;
   logic [WIDTH-1:0]      wb_data;
   logic                  issue_en;
   logic [AW-1:0]         issue_dest;
   logic [AW-1:0]         rd_addr_a;
   logic [AW-1:0]         rd_addr_b;
   logic [WIDTH-1:0]      rd_data_a;
   logic [WIDTH-1:0]      rd_data_b;
   logic                  hazard_a;
   logic                  hazard_b;
   logic [NREG-1:0]       pending;
   logic                  load_err;
   logic [NREG*WIDTH-1:0] dbg_regs;

   modport master (
      output load_en, load_addr, load_data,
      output wb_en, wb_addr, wb_data,
      output issue_en, issue_dest,
      output rd_addr_a, rd_addr_b,
      input  rd_data_a, rd_data_b, hazard_a, hazard_b,
      input  pending, load_err, dbg_regs
   );

   modport slave (
      input  load_en, load_addr, load_data,
      input  wb_en, wb_addr, wb_data,
      input  issue_en, issue_dest,
      input  rd_addr_a, rd_addr_b,
      output rd_data_a, rd_data_b, hazard_a, hazard_b,
      output pending, load_err, dbg_regs
   );

endinterface

// File: rtl/rf_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard
//   Pending-writeback scoreboard for the register file.
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     issue_en, issue_dest      set pending[issue_dest]
//     wb_en, wb_addr            clear pending[wb_addr]
//     rd_addr_a, rd_addr_b      addresses to look up for hazards
//     pending                   current scoreboard bits
//     hazard_a, hazard_b        registered hazard flags for the two read ports
// ---------------------------------------------------------------------------
module rf_scoreboard
   import reg_file_pkg::*;
#(
   parameter int NREG = DEF_NREG,
   parameter int AW   = calc_aw(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            issue_en,
   input  logic [AW-1:0]   issue_dest,
   input  logic            wb_en,
   input  logic [AW-1:0]   wb_addr,
   input  logic [AW-1:0]   rd_addr_a,
   input  logic [AW-1:0]   rd_addr_b,
   output logic [NREG-1:0] pending,
   output logic            hazard_a,
   output logic            hazard_b
);

   logic [NREG-1:0]     pend_next;
   logic [1:0][AW-1:0]  rd_addr;
   logic [1:0]          haz_next;
   logic                issue_ok;
   logic                wb_ok;

   assign rd_addr  = {rd_addr_b, rd_addr_a};
   assign issue_ok = issue_en && addr_ok(32'(issue_dest), NREG);
   assign wb_ok    = wb_en && addr_ok(32'(wb_addr), NREG);

   // Clear first, then set: an issue landing on the register being written
   // back belongs to a newer instruction, so the bit must stay set.
   always_comb begin
      pend_next = pending;
      if (wb_ok)
         pend_next[wb_addr] = 1'b0;
      if (issue_ok)
         pend_next[issue_dest] = 1'b1;
   end

   // Hazard uses the pre-update bits: a same-cycle writeback is bypassed into
   // the operand so it clears the hazard, a same-cycle issue does not raise it.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         haz_next[p] = 1'b0;
         if (addr_ok(32'(rd_addr[p]), NREG))
            haz_next[p] = pending[rd_addr[p]] && !(wb_en && (wb_addr == rd_addr[p]));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending  <= '0;
         hazard_a <= 1'b0;
         hazard_b <= 1'b0;
      end else begin
         pending  <= pend_next;
         hazard_a <= haz_next[0];
         hazard_b <= haz_next[1];
      end
   end

endmodule

// File: rtl/reg_file_param.sv
// ---------------------------------------------------------------------------
// reg_file_param
//   Parametrised register file between the command decoder and the ALU.
//   Host loads and ALU writebacks commit in the same cycle when they target
//   different registers; two registered read ports bypass same-cycle writes;
//   a pending-writeback scoreboard flags read hazards and rejects host loads
//   to registers whose result is still in flight.
//   Ports:
//     clk   system clock, all state on the rising edge
//     rst   synchronous active-high reset
//     bus   reg_file_param_if.slave (load, writeback, issue, reads, status)
// ---------------------------------------------------------------------------
module reg_file_param
   import reg_file_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NREG  = DEF_NREG
) (
   input logic             clk,
   input logic             rst,
   reg_file_param_if.slave bus
);

   localparam int AW = calc_aw(NREG);

   logic [NREG-1:0][WIDTH-1:0] regs;
   logic [NREG-1:0]            pending;

   logic                       wb_ok;
   logic                       load_in;
   logic                       load_pend;
   logic                       load_hit_wb;
   logic                       load_ok;
   logic                       load_rej;
   logic                       load_err_q;

   logic [1:0][AW-1:0]         rd_addr;
   src_sel_e                   sel [2];
   logic [1:0][WIDTH-1:0]      rd_next;
   logic [1:0][WIDTH-1:0]      rd_q;

   assign rd_addr = {bus.rd_addr_b, bus.rd_addr_a};

   // ---------------- write arbitration ----------------
   // Out-of-range targets are silently ignored, so they never produce load_err.
   always_comb begin
      wb_ok       = bus.wb_en && addr_ok(32'(bus.wb_addr), NREG);
      load_in     = bus.load_en && addr_ok(32'(bus.load_addr), NREG);
      load_pend   = 1'b0;
      if (load_in)
         load_pend = pending[bus.load_addr];
      // The ALU result is authoritative, so it beats a host load to the same register.
      load_hit_wb = bus.wb_en && (bus.wb_addr == bus.load_addr);
      load_rej    = load_in && (load_pend || load_hit_wb);
      load_ok     = load_in && !load_pend && !load_hit_wb;
   end

   // ---------------- read bypass ----------------
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         sel[p]     = SRC_REG;
         rd_next[p] = '0;
         if (wb_ok && (bus.wb_addr == rd_addr[p]))
            sel[p] = SRC_WB;
         else if (load_ok && (bus.load_addr == rd_addr[p]))
            sel[p] = SRC_LOAD;
         if (addr_ok(32'(rd_addr[p]), NREG)) begin
            case (sel[p])
               SRC_WB:   rd_next[p] = bus.wb_data;
               SRC_LOAD: rd_next[p] = bus.load_data;
               default:  rd_next[p] = regs[rd_addr[p]];
            endcase
         end
      end
   end

   // ---------------- storage and output registers ----------------
   // load_ok already excludes the writeback address, so both writes may
   // commit in the same cycle without conflict.
   always_ff @(posedge clk) begin
      if (rst) begin
         regs       <= '0;
         rd_q       <= '0;
         load_err_q <= 1'b0;
      end else begin
         if (wb_ok)
            regs[bus.wb_addr] <= bus.wb_data;
         if (load_ok)
            regs[bus.load_addr] <= bus.load_data;
         rd_q       <= rd_next;
         load_err_q <= load_rej;
      end
   end

   // ---------------- scoreboard ----------------
   rf_scoreboard #(
      .NREG (NREG),
      .AW   (AW)
   ) u_sb (
      .clk        (clk),
      .rst        (rst),
      .issue_en   (bus.issue_en),
      .issue_dest (bus.issue_dest),
      .wb_en      (bus.wb_en),
      .wb_addr    (bus.wb_addr),
      .rd_addr_a  (bus.rd_addr_a),
      .rd_addr_b  (bus.rd_addr_b),
      .pending    (pending),
      .hazard_a   (bus.hazard_a),
      .hazard_b   (bus.hazard_b)
   );

   assign bus.rd_data_a = rd_q[0];
   assign bus.rd_data_b = rd_q[1];
   assign bus.pending   = pending;
   assign bus.load_err  = load_err_q;
   assign bus.dbg_regs  = regs;

endmodule
